// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller: 16x11 character/error store, LSR status
// flags, trigger-level and character-timeout interrupt generation.
module uart_rx_fifo_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_pulse,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pe_in,
    input  logic       fe_in,
    input  logic       bi_in,
    input  logic       rd,
    input  logic       lsr_rd,
    input  logic       fifo_en,
    input  logic       rx_fifo_reset,
    input  logic [1:0] trig_lvl,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    output logic [7:0] dout,
    output logic       dr,
    output logic       oe,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_fifo_err,
    output logic       rx_data_irq,
    output logic       timeout_irq,
    output logic [4:0] count
);

    logic [10:0] mem_q [16];
    logic [3:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [4:0]  count_q, count_d;
    logic [9:0]  tcnt_q, tcnt_d;
    logic        oe_q, oe_d, pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
    logic        hl_q, fen_q;

    logic        flush, full, empty, rd_ok, wr, ovw, ovr, head_load;
    logic [4:0]  depth, thr;
    logic [10:0] entry, head;
    logic [3:0]  bits_n;
    logic [9:0]  limit;
    logic        err_any;
    logic [3:0]  off;

    // A change of fifo_en flushes exactly like an FCR[1] strobe
    assign flush = rx_fifo_reset | (fifo_en ^ fen_q);
    assign depth = fifo_en ? 5'd16 : 5'd1;
    assign empty = (count_q == 5'd0);
    assign full  = (count_q == depth);
    assign rd_ok = rd & ~empty & ~flush;
    assign wr    = push & ~flush & (~full | rd_ok);
    assign ovr   = push & ~flush & full & ~rd_ok;
    assign ovw   = ovr & ~fifo_en;
    assign entry = {bi_in, fe_in, pe_in, din};
    assign head  = mem_q[rptr_q];

    // Pop+write on a single entry also replaces the head
    assign head_load = (wr & empty)
                     | (rd_ok & ((count_q > 5'd1) | wr))
                     | ovw;

    assign bits_n = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
    assign limit  = {bits_n, 6'b000000};

    always_comb begin
        thr = 5'd1;
        unique case (trig_lvl)
            2'b00: thr = 5'd1;
            2'b01: thr = 5'd4;
            2'b10: thr = 5'd8;
            2'b11: thr = 5'd14;
        endcase
    end

    always_comb begin
        err_any = 1'b0;
        off     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            off = 4'(i) - rptr_q;
            if ({1'b0, off} < count_q)
                err_any = err_any | (|mem_q[i][10:8]);
        end
    end

    always_comb begin
        wptr_d  = wptr_q + {3'b000, wr};
        rptr_d  = rptr_q + {3'b000, rd_ok};
        count_d = count_q;
        if (wr && !rd_ok)
            count_d = count_q + 5'd1;
        else if (rd_ok && !wr)
            count_d = count_q - 5'd1;
        tcnt_d = tcnt_q;
        if (flush || push || rd_ok || empty)
            tcnt_d = 10'd0;
        else if (fifo_en && baud_pulse && tcnt_q < limit)
            tcnt_d = tcnt_q + 10'd1;
        if (flush) begin
            wptr_d  = 4'd0;
            rptr_d  = 4'd0;
            count_d = 5'd0;
        end
        oe_d = ovr | (oe_q & ~lsr_rd);
        pe_d = (hl_q & ~empty & head[8]) | (pe_q & ~lsr_rd);
        fe_d = (hl_q & ~empty & head[9]) | (fe_q & ~lsr_rd);
        bi_d = (hl_q & ~empty & head[10]) | (bi_q & ~lsr_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            tcnt_q  <= '0;
            oe_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bi_q    <= 1'b0;
            hl_q    <= 1'b0;
            fen_q   <= 1'b0;
        end else begin
            if (wr)
                mem_q[wptr_q] <= entry;
            else if (ovw)
                mem_q[rptr_q] <= entry;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            tcnt_q  <= tcnt_d;
            oe_q    <= oe_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            bi_q    <= bi_d;
            hl_q    <= head_load;
            fen_q   <= fifo_en;
        end
    end

    assign count       = count_q;
    assign dr          = ~empty;
    assign dout        = empty ? 8'h00 : head[7:0];
    assign oe          = oe_q;
    assign pe          = pe_q;
    assign fe          = fe_q;
    assign bi          = bi_q;
    assign rx_fifo_err = fifo_en & err_any;
    assign rx_data_irq = fifo_en ? (count_q >= thr) : ~empty;
    assign timeout_irq = fifo_en & ~empty & (tcnt_q >= limit);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: vector table plus corner-case
// sequences for overrun, timeout, full push+rd, non-FIFO mode and reset.
module tb_uart_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_pulse, push, pe_in, fe_in, bi_in, rd, lsr_rd;
    logic       fifo_en, rx_fifo_reset, stb, pen;
    logic [7:0] din;
    logic [1:0] trig_lvl, wls;
    logic [7:0] dout;
    logic       dr, oe, pe, fe, bi, rx_fifo_err, rx_data_irq, timeout_irq;
    logic [4:0] count;

    int n_chk = 0;
    int n_fail = 0;

    uart_rx_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .push(push),
        .din(din), .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .rd(rd),
        .lsr_rd(lsr_rd), .fifo_en(fifo_en), .rx_fifo_reset(rx_fifo_reset),
        .trig_lvl(trig_lvl), .wls(wls), .stb(stb), .pen(pen), .dout(dout),
        .dr(dr), .oe(oe), .pe(pe), .fe(fe), .bi(bi),
        .rx_fifo_err(rx_fifo_err), .rx_data_irq(rx_data_irq),
        .timeout_irq(timeout_irq), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [7:0] din;
        logic [2:0] flg;
        logic       rd;
        logic       lsr;
        logic       frst;
        logic [4:0] e_cnt;
        logic [7:0] e_dout;
        logic       e_oe, e_pe, e_fe, e_bi, e_err, e_irq;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic p, input logic [7:0] d,
                                input logic [2:0] f, input logic r,
                                input logic l, input logic fr,
                                input logic [4:0] c, input logic [7:0] o,
                                input logic eo, input logic ep,
                                input logic ef, input logic eb,
                                input logic ee, input logic ei);
        vec_t v;
        v.push = p; v.din = d; v.flg = f; v.rd = r; v.lsr = l; v.frst = fr;
        v.e_cnt = c; v.e_dout = o; v.e_oe = eo; v.e_pe = ep; v.e_fe = ef;
        v.e_bi = eb; v.e_err = ee; v.e_irq = ei;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic [7:0] d,
                        input logic [2:0] f, input logic r, input logic l,
                        input logic fr, input logic bp);
        push = p; din = d; {bi_in, fe_in, pe_in} = f; rd = r;
        lsr_rd = l; rx_fifo_reset = fr; baud_pulse = bp;
        @(posedge clk);
        #1;
        push = 1'b0; din = 8'h00; {bi_in, fe_in, pe_in} = 3'b000;
        rd = 1'b0; lsr_rd = 1'b0; rx_fifo_reset = 1'b0; baud_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dout"}, dout, 0);
        chk({tag, ".dr"}, dr, 0);
        chk({tag, ".oe"}, oe, 0);
        chk({tag, ".pe_fe_bi"}, {pe, fe, bi}, 0);
        chk({tag, ".err"}, rx_fifo_err, 0);
        chk({tag, ".rxirq"}, rx_data_irq, 0);
        chk({tag, ".toirq"}, timeout_irq, 0);
        chk({tag, ".count"}, count, 0);
    endtask

    initial begin
        // push din flg rd lsr frst | cnt dout oe pe fe bi err irq
        tbl[0]  = mk(1, 8'h01, 0, 0, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'h02, 0, 0, 0, 0, 2, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 8'h03, 0, 0, 0, 0, 3, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 8'h04, 0, 0, 0, 0, 4, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 8'h05, 0, 0, 0, 0, 5, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 8'h06, 0, 0, 0, 0, 6, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 8'h07, 0, 0, 0, 0, 7, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 8'h08, 0, 0, 0, 0, 8, 8'h01, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(0, 8'h00, 0, 1, 0, 0, 7, 8'h02, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 8'h55, 0, 0, 0, 0, 1, 8'h55, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 8'hAA, 1, 0, 0, 0, 2, 8'h55, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 8'h00, 0, 1, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 1, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 0, 0, 1, 8'hAA, 0, 1, 0, 0, 1, 0);
        tbl[14] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 8'h33, 2, 0, 0, 0, 1, 8'h33, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h33, 0, 0, 1, 0, 1, 0);
        tbl[18] = mk(1, 8'h44, 4, 0, 1, 0, 2, 8'h33, 0, 0, 0, 0, 1, 0);
        tbl[19] = mk(0, 8'h00, 0, 1, 0, 0, 1, 8'h44, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h44, 0, 0, 0, 1, 1, 0);
        tbl[21] = mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h44, 0, 0, 0, 0, 1, 0);
        tbl[22] = mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0; fifo_en = 1'b1; trig_lvl = 2'b10;
        wls = 2'b11; pen = 1'b1; stb = 1'b0;
        push = 0; din = 0; {bi_in, fe_in, pe_in} = 0; rd = 0; lsr_rd = 0;
        rx_fifo_reset = 0; baud_pulse = 0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk_all_zero("post_reset");

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].push, tbl[i].din, tbl[i].flg, tbl[i].rd,
                 tbl[i].lsr, tbl[i].frst, 1'b0);
            chk($sformatf("row%0d.count", i), count, tbl[i].e_cnt);
            chk($sformatf("row%0d.dout", i), dout, tbl[i].e_dout);
            chk($sformatf("row%0d.dr", i), dr, int'(tbl[i].e_cnt != 0));
            chk($sformatf("row%0d.oe", i), oe, tbl[i].e_oe);
            chk($sformatf("row%0d.pe", i), pe, tbl[i].e_pe);
            chk($sformatf("row%0d.fe", i), fe, tbl[i].e_fe);
            chk($sformatf("row%0d.bi", i), bi, tbl[i].e_bi);
            chk($sformatf("row%0d.err", i), rx_fifo_err, tbl[i].e_err);
            chk($sformatf("row%0d.rxirq", i), rx_data_irq, tbl[i].e_irq);
        end

        // character timeout: 11 bits/char -> 4*176 = 704 ticks
        step(0, 8'h00, 0, 0, 0, 1, 0);
        step(1, 8'h5A, 0, 0, 0, 0, 0);
        for (int k = 0; k < 703; k++)
            step(0, 8'h00, 0, 0, 0, 0, 1);
        chk("to.before", timeout_irq, 0);
        step(0, 8'h00, 0, 0, 0, 0, 1);
        chk("to.at704", timeout_irq, 1);
        for (int k = 0; k < 5; k++)
            step(0, 8'h00, 0, 0, 0, 0, 1);
        chk("to.saturate", timeout_irq, 1);
        step(0, 8'h00, 0, 1, 0, 0, 0);
        chk("to.rd_clear", timeout_irq, 0);
        chk("to.count", count, 0);

        // overrun: 17 pushes, no rd
        step(0, 8'h00, 0, 0, 0, 1, 0);
        for (int k = 0; k < 16; k++)
            step(1, 8'h10 + 8'(k), 0, 0, 0, 0, 0);
        chk("ovr.count16", count, 16);
        chk("ovr.oe_pre", oe, 0);
        step(1, 8'h20, 0, 0, 0, 0, 0);
        chk("ovr.count", count, 16);
        chk("ovr.oe", oe, 1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovr.dout%0d", k), dout, 8'h10 + 8'(k));
            step(0, 8'h00, 0, 1, 0, 0, 0);
        end
        chk("ovr.empty", count, 0);
        chk("ovr.oe_sticky", oe, 1);
        step(0, 8'h00, 0, 0, 1, 0, 0);
        chk("ovr.oe_clr", oe, 0);

        // full push+rd, then drain with trigger 14
        for (int k = 0; k < 16; k++)
            step(1, 8'h80 + 8'(k), 0, 0, 0, 0, 0);
        step(1, 8'hEE, 0, 1, 0, 0, 0);
        chk("fpr.count", count, 16);
        chk("fpr.oe", oe, 0);
        chk("fpr.head", dout, 8'h81);
        trig_lvl = 2'b11;
        #1;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("fpr.dout%0d", k), dout, 8'h81 + 8'(k));
            chk($sformatf("fpr.irq%0d", k), rx_data_irq,
                int'((16 - k) >= 14));
            step(0, 8'h00, 0, 1, 0, 0, 0);
        end
        chk("fpr.last", dout, 8'hEE);
        step(0, 8'h00, 0, 1, 0, 0, 0);
        chk("fpr.empty", count, 0);

        // non-FIFO mode, then reset mid-stream
        fifo_en = 1'b0;
        idle(1);
        step(1, 8'h11, 0, 0, 0, 0, 0);
        chk("nf.count1", count, 1);
        chk("nf.dout1", dout, 8'h11);
        chk("nf.irq_dr", rx_data_irq, 1);
        chk("nf.oe1", oe, 0);
        step(1, 8'h22, 0, 0, 0, 0, 0);
        chk("nf.dout2", dout, 8'h22);
        chk("nf.oe2", oe, 1);
        chk("nf.count2", count, 1);
        chk("nf.err", rx_fifo_err, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk_all_zero("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
